// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with HI/LO results.
// Define DIV_ZERO_FAST_EN to short-circuit divide-by-zero straight to DONE.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             qneg;
  logic             rneg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  assign a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
  assign b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

  assign stall = ((state == IDLE) && start && !cancel)
               || (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      cnt       <= '0;
      ready     <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      ready <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              dvs   <= b_abs;
              quo   <= a_abs;
              rem   <= '0;
              qneg  <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg  <= signed_div & a[WIDTH-1];
              cnt   <= '0;
              state <= BUSY;
`ifdef DIV_ZERO_FAST_EN
              // cnt=1 holds DONE one extra cycle so ready lands at edge 2
              if (b == '0) begin
                quo   <= '1;
                rem   <= a;
                qneg  <= 1'b0;
                rneg  <= 1'b0;
                cnt   <= CW'(1);
                state <= DONE;
              end
`endif
            end
          end
          BUSY: begin
            if (diff[WIDTH]) begin
              rem <= rem_sh[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              cnt   <= '0;
              state <= DONE;
            end
          end
          DONE: begin
            if (cnt != '0) begin
              cnt <= '0;
            end else begin
              result_lo <= qneg ? -quo : quo;
              result_hi <= rneg ? -rem : rem;
              ready     <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: scoreboard of expected HI/LO results,
// latency, stall, cancel and asynchronous reset behaviour.
module tb_div_iter;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic         stall;
  logic         ready;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .stall      (stall),
    .ready      (ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide, push expectation, wait for ready and compare.
  task automatic do_div(input string tag,
                        input logic sd,
                        input logic [W-1:0] aa,
                        input logic [W-1:0] bb,
                        input logic [W-1:0] elo,
                        input logic [W-1:0] ehi,
                        input int lat);
    exp_t e;
    int   got;
    logic stall_ok;
    logic stall_rdy;
    stall_ok  = 1'b1;
    stall_rdy = 1'b1;
    got       = -1;
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = sd;
    a          = aa;
    b          = bb;
    sb.push_back('{lo: elo, hi: ehi, lat: lat});
    #1;
    if (stall !== 1'b1) stall_ok = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k <= lat + 4; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      if (ready === 1'b1) begin
        got       = k;
        stall_rdy = stall;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
    end
    e = sb.pop_front();
    check({tag, " latency"}, W'(got), W'(e.lat));
    check({tag, " lo"}, result_lo, e.lo);
    check({tag, " hi"}, result_hi, e.hi);
    check({tag, " stall busy"}, W'(stall_ok), W'(1));
    check({tag, " stall at ready"}, W'(stall_rdy), W'(0));
  endtask

  initial begin
    logic seen_rdy;
    logic seen_stall;
    int   zlat;
    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    a          = '0;
    b          = '0;
    cancel     = 1'b0;
    #12;
    check("reset ready", W'(ready), W'(0));
    check("reset stall", W'(stall), W'(0));
    check("reset lo", result_lo, 32'h0);
    check("reset hi", result_hi, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7,
           32'd14, 32'd2, W + 1);
    do_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFD, 32'hFFFFFFFF, W + 1);
    do_div("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 32'h0, W + 1);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE,
           32'hFFFFFFFD, 32'd1, W + 1);

    // cancel at cycle 10 of a DIVU 1000/3
    @(posedge clk);
    #1;
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd1000;
    b          = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    seen_rdy   = 1'b0;
    seen_stall = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen_rdy = 1'b1;
      if (stall) seen_stall = 1'b1;
    end
    check("cancel no ready", W'(seen_rdy), W'(0));
    check("cancel stall low", W'(seen_stall), W'(0));
    check("cancel lo kept", result_lo, 32'hFFFFFFFD);
    check("cancel hi kept", result_hi, 32'd1);

    do_div("divu 9/4", 1'b0, 32'd9, 32'd4,
           32'd2, 32'd1, W + 1);

    // asynchronous reset at cycle 15 of a DIVU
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 32'd1000;
    b     = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst ready", W'(ready), W'(0));
    check("arst stall", W'(stall), W'(0));
    check("arst lo", result_lo, 32'h0);
    check("arst hi", result_hi, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    seen_rdy   = 1'b0;
    seen_stall = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen_rdy = 1'b1;
      if (stall) seen_stall = 1'b1;
    end
    check("post-rst idle ready", W'(seen_rdy), W'(0));
    check("post-rst idle stall", W'(seen_stall), W'(0));

`ifdef DIV_ZERO_FAST_EN
    zlat = 2;
`else
    zlat = W + 1;
`endif
    do_div("divu 5/0", 1'b0, 32'd5, 32'd0,
           32'hFFFFFFFF, 32'd5, zlat);

    do_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1,
           32'hFFFFFFFF, 32'd0, W + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider for the EX stage, computing 32-bit signed or unsigned quotient and remainder in HI/LO form. While it runs, it raises `stall` combinationally. The hazard logic uses `stall` to drop the `enable` of the upstream pipeline registers and to `clear` the EX/MEM register. `cancel` is driven by the exception/flush path so that a killed DIV/DIVU leaves no result.

## Interface
- `WIDTH`, default 32: operand and result width; must be even and ≥ 4.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-low (0 = reset).
- `start`  in  1  request a divide; sampled only in IDLE.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `a`  in  WIDTH  dividend; sampled with `start`.
- `b`  in  WIDTH  divisor; sampled with `start`.
- `cancel`  in  1  abort the current or requested operation.
- `stall`  out  1  pipeline hold request.
- `ready`  out  1  one-cycle pulse: `result_lo`/`result_hi` hold a new result.
- `result_lo`  out  WIDTH  quotient.
- `result_hi`  out  WIDTH  remainder.

## Operation
- States are IDLE, BUSY and DONE, encoded in 2 bits; reset state is IDLE.
- IDLE:
  - `start`=1 and `cancel`=0: latch |a|, |b| (absolute values only when `signed_div`=1), quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB]. Clear iteration counter; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, each cycle:
  - Shift {rem, dividend} left by 1, then trial-subtract divisor from rem.
  - If no borrow: keep the difference and set quotient bit to 1; else set it to 0.
  - Counter increments each cycle. After exactly WIDTH iterations, go to DONE.
- DONE: apply signs (two's-complement negate where the sign flag is set), load `result_lo`/`result_hi`, pulse `ready`, return to IDLE.
- `cancel`=1 in any state: next state is IDLE. Counter is cleared, `ready` is not pulsed and result registers are unchanged. In IDLE, `cancel` overrides a simultaneous `start`.
- `start` asserted in BUSY or DONE is ignored; the requester holds it under `stall`.
- `result_lo`/`result_hi` hold their value until the next DONE. They are not cleared by `cancel`.
- Signed overflow (a = 100…0, b = all ones) needs no special case: quotient = 100…0, remainder = 0.
- Reset (rst=0) at any time, including mid-BUSY:
  - State goes to IDLE and the counter to 0.
  - `ready`=0, `stall`=0, `result_lo`=0, `result_hi`=0, all internal datapath registers 0.

## Timing
- `stall` = (IDLE & `start` & !`cancel`) | BUSY | DONE. It is combinational, so the pipeline freezes in the same cycle the DIV is presented.
- With `start` accepted at edge 0, the operation enters BUSY at edge 0 and DONE at edge WIDTH. `ready`=1 and the results are valid from edge WIDTH+1 for one cycle. That is 33 cycles at WIDTH=32; `stall` is high for cycles 0…WIDTH.
- `ready` is registered and high for exactly one cycle; `stall` is low in that same cycle, so the pipeline advances and consumes the results.
- Back-to-back: a new `start` is accepted in the cycle `ready` is high, since the block is already in IDLE.
- `cancel` takes effect at the next edge; `stall` is low from the cycle after `cancel`.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - An accepted `start` with b = 0 skips BUSY and goes directly to DONE.
  - Result is quotient = all ones, remainder = a (raw, unsigned interpretation), with `ready` at edge 2.
- Not defined:
  - b = 0 runs the full WIDTH iterations with normal timing.
  - Result is whatever the restoring algorithm produces: unsigned quotient all ones, remainder = a; signed results get the sign fix-up applied.
- MIPS leaves division by zero UNPREDICTABLE, so both modes are architecturally legal; the bench checks the values listed here for the active mode.

## Test plan
- DIVU 100 / 7 at edge 0 -> `stall` high for cycles 0–32; `ready` at cycle 33 with `result_lo`=14, `result_hi`=2.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> `result_lo`=0xFFFFFFFD (-3), `result_hi`=0xFFFFFFFF (-1); DIV 7 / -2 -> `result_lo`=0xFFFFFFFD, `result_hi`=1.
- DIV 0x80000000 / 0xFFFFFFFF -> `result_lo`=0x80000000, `result_hi`=0 at cycle 33.
- DIVU 1000 / 3, `cancel` at cycle 10:
  - `stall` low from cycle 11, no `ready` ever, results unchanged.
  - A subsequent DIVU 9 / 4 gives 2 / 1 after 33 cycles.
- `rst` pulled low at cycle 15 of a DIVU -> all outputs 0 immediately (asynchronous); after release, `start`=0 keeps the block in IDLE with `stall`=0.
- DIVU 5 / 0:
  - With `DIV_ZERO_FAST_EN`: `ready` at cycle 2, `result_lo`=0xFFFFFFFF, `result_hi`=5.
  - Without it: the same values with `ready` at cycle 33.
